// File: rtl/ioctl_dn_pkg.sv
// Shared types and constants for the hps_io download controller.
// Holds the FSM state enum, download index map and target bit positions.
package ioctl_dn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } dn_state_t;

   typedef logic [1:0] tgt_sel_t;

   localparam logic [7:0] IDX_BIOS   = 8'd0;
   localparam logic [7:0] IDX_SPRITE = 8'd3;
   localparam logic [7:0] IDX_MUSIC  = 8'd4;

   localparam tgt_sel_t SEL_BIOS   = 2'd0;
   localparam tgt_sel_t SEL_SPRITE = 2'd1;
   localparam tgt_sel_t SEL_MUSIC  = 2'd2;

   localparam int          NUM_TGT    = 3;
   localparam int          FIFO_W     = 25;
   localparam logic [24:0] ADDR_LIMIT = 25'h0020000;

   function automatic logic idx_valid(input logic [7:0] idx);
      return (idx == IDX_BIOS) || (idx == IDX_SPRITE) || (idx == IDX_MUSIC);
   endfunction

   function automatic tgt_sel_t idx_to_sel(input logic [7:0] idx);
      tgt_sel_t s;
      case (idx)
         IDX_SPRITE: s = SEL_SPRITE;
         IDX_MUSIC:  s = SEL_MUSIC;
         default:    s = SEL_BIOS;
      endcase
      return s;
   endfunction

   function automatic logic [NUM_TGT-1:0] sel_onehot(input tgt_sel_t s);
      return 3'b001 << s;
   endfunction

endpackage

// File: rtl/ioctl_dn_ctrl_fifo.sv
// Small synchronous FIFO buffering {address, data} bytes between hps_io and a target.
// Occupancy is exposed so the controller can raise backpressure early.
module dn_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing reads it until an entry has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ioctl_dn_ctrl.sv
// Routes hps_io byte downloads to the BIOS, sprite ROM or music target through a FIFO,
// and holds the core in reset around BIOS loads.
module ioctl_dn_ctrl
   import ioctl_dn_pkg::*;
#(
   parameter int RST_HOLD   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [2:0]  tgt_req,
   output logic [16:0] tgt_addr,
   output logic [7:0]  tgt_data,
   input  logic [2:0]  tgt_ack,
   output logic        core_reset,
   output logic [2:0]  dn_done,
   output logic [17:0] dn_count,
   output logic        dn_err,
   output dn_state_t   dbg_state
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 4");
   end

   // Handshake: tgt_req[sel] is valid while the FIFO holds data; a byte is consumed
   // on any cycle where tgt_req[sel] and tgt_ack[sel] are both high. Head is stable until then.
   dn_state_t         state;
   dn_state_t         state_nxt;
   tgt_sel_t          sel;
   logic [HW-1:0]     hold_cnt;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_W-1:0] fifo_head;
   logic [2:0]        sel_mask;
   logic              in_range;
   logic              push;
   logic              drop;
   logic              pop;
   logic              start_load;
   logic              enter_hold;

   assign sel_mask = sel_onehot(sel);
   assign in_range = (ioctl_addr < ADDR_LIMIT);
   assign pop      = !fifo_empty && tgt_ack[sel];

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      start_load = 1'b0;
      enter_hold = 1'b0;
      push       = 1'b0;
      drop       = 1'b0;
      dn_done    = '0;
      case (state)
         ST_IDLE: begin
            if (ioctl_download && idx_valid(ioctl_index)) begin
               state_nxt  = ST_LOAD;
               start_load = 1'b1;
            end
         end
         ST_LOAD: begin
            if (ioctl_wr) begin
               if (in_range && !fifo_full) push = 1'b1;
               else                        drop = 1'b1;
            end
            if (!ioctl_download) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               if (dn_count != '0) dn_done = sel_mask;
               if (sel == SEL_BIOS) begin
                  state_nxt  = ST_HOLD;
                  enter_hold = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_HOLD: begin
            if (hold_cnt == '0) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sel      <= SEL_BIOS;
         dn_count <= '0;
         dn_err   <= 1'b0;
         hold_cnt <= '0;
      end else begin
         if (start_load) begin
            sel      <= idx_to_sel(ioctl_index);
            dn_count <= '0;
            dn_err   <= 1'b0;
         end else begin
            if (push) dn_count <= dn_count + 18'd1;
            if (drop) dn_err   <= 1'b1;
         end
         // Loaded with RST_HOLD-1 so HOLD spans exactly RST_HOLD cycles.
         if (enter_hold)                                hold_cnt <= HW'(RST_HOLD - 1);
         else if ((state == ST_HOLD) && (hold_cnt != '0)) hold_cnt <= hold_cnt - HW'(1);
      end
   end

   dn_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_sys),
      .rst   (reset),
      .push  (push),
      .wdata ({ioctl_addr[16:0], ioctl_dout}),
      .pop   (pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Threshold leaves one slot free for a write already in flight when wait rises.
   assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 2));
   assign tgt_req    = fifo_empty ? 3'b000 : sel_mask;
   assign tgt_addr   = fifo_head[24:8];
   assign tgt_data   = fifo_head[7:0];
   assign core_reset = (sel == SEL_BIOS) && (state != ST_IDLE);
   assign dbg_state  = state;

endmodule

// File: tb/tb_ioctl_dn_ctrl.sv
// Directed-plus-random bench for ioctl_dn_ctrl with a queue-based reference of delivered bytes.
module tb_ioctl_dn_ctrl;
   import ioctl_dn_pkg::*;

   localparam int          RST_HOLD   = 16;
   localparam int          FIFO_DEPTH = 4;
   localparam logic [24:0] LIMIT      = 25'h0020000;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = '0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        ioctl_wait;
   logic [2:0]  tgt_req;
   logic [16:0] tgt_addr;
   logic [7:0]  tgt_data;
   logic [2:0]  tgt_ack = '0;
   logic        core_reset;
   logic [2:0]  dn_done;
   logic [17:0] dn_count;
   logic        dn_err;
   dn_state_t   dbg_state;

   always #5 clk_sys = ~clk_sys;

   ioctl_dn_ctrl #(
      .RST_HOLD   (RST_HOLD),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .tgt_req        (tgt_req),
      .tgt_addr       (tgt_addr),
      .tgt_data       (tgt_data),
      .tgt_ack        (tgt_ack),
      .core_reset     (core_reset),
      .dn_done        (dn_done),
      .dn_count       (dn_count),
      .dn_err         (dn_err),
      .dbg_state      (dbg_state)
   );

   // Reference model: bytes the targets must receive, in order.
   logic [24:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_sel = 0;
   bit          m_loading = 1'b0;
   int          m_count = 0;
   bit          m_err = 1'b0;
   int          ack_mode = 1;   // 0: selected ack low, 1: high, 2: random
   bit          cr_seen = 1'b0;
   logic [7:0]  idx_tab [3] = '{8'd0, 8'd3, 8'd4};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ack();
      logic [2:0] a;
      a = 3'($urandom);
      if (ack_mode == 0)      a[exp_sel] = 1'b0;
      else if (ack_mode == 1) a[exp_sel] = 1'b1;
      tgt_ack = a;
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
      ioctl_wr = 1'b0;
      drive_ack();
   endtask

   task automatic model_write(input logic [24:0] a, input logic [7:0] d);
      if (m_loading) begin
         if (a < LIMIT) begin
            exp_q.push_back({a[16:0], d});
            m_count++;
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input bit obey);
      int n;
      n = 0;
      while (obey && ioctl_wait && n < 500) begin
         step();
         n++;
      end
      if (n >= 500) check("wait_timeout", 32'(n), 32'(0));
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      model_write(a, d);
      step();
   endtask

   task automatic start_dl(input logic [7:0] idx, input int sel_bit);
      exp_sel        = sel_bit;
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      step();
      m_loading = 1'b1;
      m_count   = 0;
      m_err     = 1'b0;
      check("load_state", 32'(dbg_state), 32'(ST_LOAD));
      check("count_clear", 32'(dn_count), 32'(0));
      check("err_clear", 32'(dn_err), 32'(0));
      check("core_reset_load", 32'(core_reset), 32'(sel_bit == 0));
   endtask

   task automatic finish_dl(input bit is_bios);
      int n;
      ioctl_download = 1'b0;
      step();
      m_loading = 1'b0;
      n = 0;
      while (dn_done == 3'b000 && n < 500) begin
         step();
         n++;
      end
      check("done_mask", 32'(dn_done), (m_count > 0) ? (32'(1) << exp_sel) : 32'(0));
      check("done_count", 32'(dn_count), 32'(m_count));
      check("done_err", 32'(dn_err), 32'(m_err));
      check("all_delivered", 32'(exp_q.size()), 32'(0));
      check("core_reset_drain", 32'(core_reset), 32'(is_bios));
      step();
      check("done_one_cycle", 32'(dn_done), 32'(0));
      if (is_bios) begin
         n = 0;
         while (core_reset && n < 100) begin
            n++;
            step();
         end
         check("hold_cycles", 32'(n), 32'(RST_HOLD));
      end
      check("back_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("core_reset_idle", 32'(core_reset), 32'(0));
   endtask

   // Target-side monitor: checks routing, head contents and consumes accepted bytes.
   always @(negedge clk_sys) begin
      if (!reset) begin
         if (core_reset) cr_seen = 1'b1;
         if (tgt_req != 3'b000) begin
            check("req_onehot", 32'(tgt_req), 32'(1) << exp_sel);
            if (exp_q.size() == 0) begin
               check("req_without_data", 32'(tgt_req), 32'(0));
            end else begin
               check("head", 32'({tgt_addr, tgt_data}), 32'(exp_q[0]));
               if ((tgt_ack & tgt_req) != 3'b000) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [24:0] a;
      logic [7:0]  d;
      int          nb;
      int          k;
      bit          any_done;

      // Reset state
      repeat (3) @(posedge clk_sys);
      #1;
      check("rst_req", 32'(tgt_req), 32'(0));
      check("rst_done", 32'(dn_done), 32'(0));
      check("rst_count", 32'(dn_count), 32'(0));
      check("rst_err", 32'(dn_err), 32'(0));
      check("rst_wait", 32'(ioctl_wait), 32'(0));
      check("rst_core_reset", 32'(core_reset), 32'(0));
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b0;
      step();

      // BIOS: 8 bytes at 0..7, selected ack held high
      ack_mode = 1;
      start_dl(IDX_BIOS, 0);
      for (int b = 0; b < 8; b++) begin
         write_byte(25'(b), 8'($urandom), 1'b1);
         repeat ($urandom_range(0, 2)) step();
      end
      finish_dl(1'b1);

      // Sprite: targets stall for 20 cycles while the host obeys ioctl_wait
      ack_mode = 0;
      cr_seen  = 1'b0;
      start_dl(IDX_SPRITE, 1);
      write_byte(25'($urandom_range(0, 32'h1FFFF)), 8'($urandom), 1'b1);
      check("wait_occ1", 32'(ioctl_wait), 32'(0));
      write_byte(25'($urandom_range(0, 32'h1FFFF)), 8'($urandom), 1'b1);
      check("wait_occ2", 32'(ioctl_wait), 32'(1));
      repeat (20) step();
      check("stall_req", 32'(tgt_req), 32'(3'b010));
      check("stall_wait", 32'(ioctl_wait), 32'(1));
      ack_mode = 1;
      for (int b = 0; b < 4; b++) write_byte(25'($urandom_range(0, 32'h1FFFF)), 8'($urandom), 1'b1);
      finish_dl(1'b0);
      check("sprite_no_core_reset", 32'(cr_seen), 32'(0));

      // Music: an out-of-range write is dropped and flags an error
      ack_mode = 2;
      start_dl(IDX_MUSIC, 2);
      for (int b = 0; b < 3; b++) write_byte(25'($urandom_range(0, 32'h1FFFF)), 8'($urandom), 1'b1);
      write_byte(25'h0020000, 8'($urandom), 1'b1);
      check("oor_err", 32'(dn_err), 32'(1));
      check("oor_count", 32'(dn_count), 32'(3));
      write_byte(25'($urandom_range(0, 32'h1FFFF)), 8'($urandom), 1'b1);
      finish_dl(1'b0);
      check("err_sticky", 32'(dn_err), 32'(1));

      // Sprite: same-cycle push and pop at occupancy 1 (also clears the error)
      ack_mode = 0;
      start_dl(IDX_SPRITE, 1);
      write_byte(25'h00100, 8'($urandom), 1'b1);
      tgt_ack[1] = 1'b1;
      a = 25'h00101;
      d = 8'($urandom);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      model_write(a, d);
      step();
      check("pp_wait", 32'(ioctl_wait), 32'(0));
      check("pp_req", 32'(tgt_req), 32'(3'b010));
      write_byte(25'h00102, 8'($urandom), 1'b1);
      check("pp_occ2_wait", 32'(ioctl_wait), 32'(1));
      ack_mode = 1;
      finish_dl(1'b0);

      // Unknown index 7: everything ignored
      exp_sel        = 0;
      ioctl_index    = 8'd7;
      ioctl_download = 1'b1;
      step();
      check("idx7_state", 32'(dbg_state), 32'(ST_IDLE));
      any_done = 1'b0;
      for (int b = 0; b < 4; b++) begin
         write_byte(25'(b), 8'($urandom), 1'b1);
         check("idx7_req", 32'(tgt_req), 32'(0));
         if (dn_done != 3'b000) any_done = 1'b1;
      end
      ioctl_download = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (dn_done != 3'b000) any_done = 1'b1;
      end
      check("idx7_no_done", 32'(any_done), 32'(0));
      check("idx7_idle", 32'(dbg_state), 32'(ST_IDLE));

      // Random downloads with random ack behaviour and occasional bad addresses
      for (int r = 0; r < 5; r++) begin
         k        = $urandom_range(0, 2);
         ack_mode = 2;
         start_dl(idx_tab[k], k);
         nb = $urandom_range(1, 10);
         for (int b = 0; b < nb; b++) begin
            if (b > 0 && $urandom_range(0, 7) == 0) a = LIMIT + 25'($urandom_range(0, 1000));
            else                                    a = 25'($urandom_range(0, 32'h1FFFF));
            write_byte(a, 8'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) step();
         end
         finish_dl(k == 0);
      end

      // Reset in the middle of a BIOS download
      ack_mode = 0;
      start_dl(IDX_BIOS, 0);
      for (int b = 0; b < 3; b++) write_byte(25'(b), 8'($urandom), 1'b0);
      check("mid_wait", 32'(ioctl_wait), 32'(1));
      reset          = 1'b1;
      ioctl_download = 1'b0;
      #2;
      exp_q.delete();
      m_loading = 1'b0;
      check("mid_rst_req", 32'(tgt_req), 32'(0));
      check("mid_rst_count", 32'(dn_count), 32'(0));
      check("mid_rst_wait", 32'(ioctl_wait), 32'(0));
      check("mid_rst_core_reset", 32'(core_reset), 32'(0));
      check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      step();
      reset = 1'b0;
      any_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (dn_done != 3'b000) any_done = 1'b1;
      end
      check("mid_no_done", 32'(any_done), 32'(0));
      check("mid_req", 32'(tgt_req), 32'(0));
      check("mid_state", 32'(dbg_state), 32'(ST_IDLE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
